booth_mul_seq: RTL and testbench

//  Sequential radix-2 Booth signed multiplier; downstream consumer of the ALU's MUL request (opcode 4'hf).

---
 rtl/booth_mul_seq.sv | 114 +++++++++++
 tb/tb_booth_mul_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock,
// sticky done/result held until the requester acknowledges with muldone_clear.
module booth_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mul_start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 muldone_clear,
  output logic [2*WIDTH-1:0]   mul_result,
  output logic                 mul_done,
  output logic                 mul_busy
);

  localparam int ACC_W = 2*WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE, S_WAIT_LOW} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       u_cur, m_ext, u_sum;
  logic [ACC_W-1:0]     acc_step;
  logic                 last_step;

  // The extra guard bit in U keeps U - (-2**(WIDTH-1)) representable.
  always_comb begin
    u_cur = acc_q[ACC_W-1:WIDTH+1];
    m_ext = {m_q[WIDTH-1], m_q};
    case (acc_q[1:0])
      2'b01:   u_sum = u_cur + m_ext;
      2'b10:   u_sum = u_cur - m_ext;
      default: u_sum = u_cur;
    endcase
    acc_step  = {u_sum[WIDTH], u_sum, acc_q[WIDTH:1]};
    last_step = (cnt_q == LAST_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (mul_start) state_d = S_EXEC;
      S_EXEC:     if (last_step) state_d = S_DONE;
      S_DONE:     if (muldone_clear) state_d = mul_start ? S_WAIT_LOW : S_IDLE;
      S_WAIT_LOW: if (!mul_start) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          m_d   = multiplicand;
          acc_d = {{(WIDTH+1){1'b0}}, multiplier, 1'b0};
          cnt_d = '0;
        end
      end
      S_EXEC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          done_d   = 1'b1;
          result_d = acc_step[2*WIDTH:1];
        end
      end
      S_DONE: begin
        if (muldone_clear) begin
          done_d   = 1'b0;
          result_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_busy   = (state_q == S_EXEC);
    mul_done   = done_q;
    mul_result = result_q;
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, multi-cycle
// corner sequences and a random batch against a signed reference product.
module tb_booth_mul_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          mul_start;
  logic [W-1:0]  multiplicand, multiplier;
  logic          muldone_clear;
  logic [2*W-1:0] mul_result;
  logic          mul_done, mul_busy;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  booth_mul_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .mul_start(mul_start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .muldone_clear(muldone_clear), .mul_result(mul_result),
    .mul_done(mul_done), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sbv;
    sa  = $signed({{W{a[W-1]}}, a});
    sbv = $signed({{W{b[W-1]}}, b});
    return sa * sbv;
  endfunction

  // Launch one op, zero the operand buses after the sampling edge, wait for done.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit hold_start, input bit clr_pulse);
    int cycles;
    int busy_cnt;
    logic [2*W-1:0] want;
    mul_start    = 1'b1;
    multiplicand = a;
    multiplier   = b;
    step();
    sb.push_back(exp);
    multiplicand = '0;
    multiplier   = '0;
    if (!hold_start) mul_start = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    while (!mul_done && cycles < 100) begin
      if (mul_busy) busy_cnt++;
      muldone_clear = clr_pulse && (cycles == 5);
      step();
      cycles++;
    end
    muldone_clear = 1'b0;
    want = sb.pop_front();
    check({name, " latency"}, 64'(cycles), 64'(W));
    check({name, " busy"}, 64'(busy_cnt), 64'(W));
    check({name, " result"}, mul_result, want);
    $display("op %s: A=%h B=%h result=%h cycles=%0d", name, a, b, mul_result, cycles);
  endtask

  task automatic clear_done(input string name);
    muldone_clear = 1'b1;
    step();
    muldone_clear = 1'b0;
    check({name, " clr done"}, 64'(mul_done), 64'd0);
    check({name, " clr result"}, mul_result, 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
    vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[5] = '{32'd0,          32'hDEAD_BEEF, 64'd0};
    vecs[6] = '{32'hDEAD_BEEF, 32'd0,         64'd0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};

    reset = 1'b1; mul_start = 1'b0; multiplicand = '0; multiplier = '0; muldone_clear = 1'b0;
    step(); step();
    check("reset done", 64'(mul_done), 64'd0);
    check("reset busy", 64'(mul_busy), 64'd0);
    check("reset result", mul_result, 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b0);
      clear_done($sformatf("vec%0d", i));
    end

    // Start held high throughout; clear with start high must not relaunch.
    run_op("hold", 32'd9, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFDC, 1'b1, 1'b0);
    clear_done("hold");
    for (int i = 0; i < 5; i++) step();
    check("hold no restart busy", 64'(mul_busy), 64'd0);
    check("hold no restart done", 64'(mul_done), 64'd0);
    mul_start = 1'b0;
    step();
    run_op("5x6", 32'd5, 32'd6, 64'd30, 1'b0, 1'b0);
    clear_done("5x6");

    // Asynchronous reset in the middle of the iteration.
    mul_start = 1'b1; multiplicand = 32'd100; multiplier = 32'd200;
    step();
    mul_start = 1'b0; multiplicand = '0; multiplier = '0;
    for (int i = 0; i < 10; i++) step();
    check("pre-reset busy", 64'(mul_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async reset busy", 64'(mul_busy), 64'd0);
    check("async reset done", 64'(mul_done), 64'd0);
    check("async reset result", mul_result, 64'd0);
    step();
    reset = 1'b0;
    step();
    run_op("12x-12", 32'd12, 32'hFFFF_FFF4, 64'hFFFF_FFFF_FFFF_FF70, 1'b0, 1'b0);
    clear_done("12x-12");

    // Clear pulsed mid-EXEC is ignored; DONE then holds for 100 cycles.
    run_op("clr-exec", 32'h1234_5678, 32'hFEDC_BA98, ref_mul(32'h1234_5678, 32'hFEDC_BA98), 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step();
    check("hold100 done", 64'(mul_done), 64'd1);
    check("hold100 result", mul_result, ref_mul(32'h1234_5678, 32'hFEDC_BA98));
    clear_done("hold100");

    for (int i = 0; i < 800; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = {a[W-1], {(W-1){a[0]}}};
      run_op($sformatf("rnd%0d", i), a, b, ref_mul(a, b), 1'b0, 1'b0);
      clear_done($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
